// File: rtl/alu_32bit.sv
// alu_32bit -- 32-bit ALU.
// Ops 000-110 (AND, OR, XOR, NOR, SLT, ADD, SUB) are purely combinational.
// Op 111 (MOD) is an unsigned a mod b computed by a repeated-subtraction FSM.
// The MOD FSM is built only when the macro ALU_MOD_EN is defined; the project
// build defines it by default. Without it, op 111 yields result=0, c_out=0.

module alu_32bit #(
   parameter int WIDTH = 32
) (
   output logic [WIDTH-1:0] result,
   output logic             c_out,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       aluOp,
   input  logic             c_in,
   input  logic             reset,
   input  logic             CLK
);

   typedef enum logic [2:0] {
      OP_AND = 3'b000,
      OP_OR  = 3'b001,
      OP_XOR = 3'b010,
      OP_NOR = 3'b011,
      OP_SLT = 3'b100,
      OP_ADD = 3'b101,
      OP_SUB = 3'b110,
      OP_MOD = 3'b111
   } alu_op_e;

   alu_op_e          op;
   logic [WIDTH:0]   add_full;
   logic [WIDTH:0]   sub_full;
   logic             slt;
   logic [WIDTH-1:0] mod_result;

   assign op = alu_op_e'(aluOp);

   // One extra bit on each adder captures the carry; SUB is a + ~b + 1 so
   // its carry reads as "no borrow".
   assign add_full = {1'b0, a} + {1'b0, b}  + {{WIDTH{1'b0}}, c_in};
   assign sub_full = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
   assign slt      = $signed(a) < $signed(b);

   // Output select: combinational ops directly, MOD from its registered result.
   always_comb begin
      // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
      result = '0;
      c_out  = 1'b0;
      case (op)
         OP_AND: result = a & b;
         OP_OR:  result = a | b;
         OP_XOR: result = a ^ b;
         OP_NOR: result = ~(a | b);
         OP_SLT: result = {{(WIDTH-1){1'b0}}, slt};
         OP_ADD: {c_out, result} = add_full;
         OP_SUB: {c_out, result} = sub_full;
         OP_MOD: result = mod_result;
         default: result = '0;
      endcase
   end

`ifdef ALU_MOD_EN
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } mod_state_e;

   mod_state_e       state_q;
   logic [WIDTH-1:0] rem_q;   // running remainder
   logic [WIDTH-1:0] dv_q;    // latched divisor (b)
   logic [WIDTH-1:0] a_q;     // latched dividend, kept for operand-change detection
   logic [WIDTH-1:0] res_q;   // registered MOD output: rem in DONE, else 0
   logic             match_d;

   // The computation stays valid only while op and both operands are unchanged.
   assign match_d = (op == OP_MOD) && (a == a_q) && (b == dv_q);

   // Remainder FSM: latch operands, subtract once per cycle, hold the remainder.
   always_ff @(posedge CLK) begin
      // NOTE: sequential state uses <= only so every register sees pre-edge values.
      if (reset) begin
         // NOTE: all FSM registers reset so an aborted run never leaks a stale remainder.
         state_q <= ST_IDLE;
         rem_q   <= '0;
         dv_q    <= '0;
         a_q     <= '0;
         res_q   <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               res_q <= '0;
               if (op == OP_MOD) begin
                  rem_q   <= a;
                  dv_q    <= b;
                  a_q     <= a;
                  state_q <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (!match_d) begin
                  state_q <= ST_IDLE;
                  res_q   <= '0;
               end else if ((dv_q == '0) || (rem_q < dv_q)) begin
                  // A zero divisor finishes at once, leaving rem = a.
                  state_q <= ST_DONE;
                  res_q   <= rem_q;
               end else begin
                  rem_q <= rem_q - dv_q;
               end
            end
            ST_DONE: begin
               if (!match_d) begin
                  state_q <= ST_IDLE;
                  res_q   <= '0;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               res_q   <= '0;
            end
         endcase
      end
   end

   assign mod_result = res_q;
`else
   // No MOD hardware: op 111 reads as zero and the clock/reset are not needed.
   logic unused_mod_ports;
   assign unused_mod_ports = &{1'b0, CLK, reset};
   assign mod_result       = '0;
`endif

endmodule

// File: tb/tb_alu_32bit.sv
// tb_alu_32bit -- self-checking bench for alu_32bit.
// Directed vectors plus randomized operands checked against a behavioural
// model built from plain arithmetic. MOD expectations follow ALU_MOD_EN.

module tb_alu_32bit;

   logic [31:0] result;
   logic        c_out;
   logic [31:0] a;
   logic [31:0] b;
   logic [2:0]  aluOp;
   logic        c_in;
   logic        reset;
   logic        CLK;

   int n_compared   = 0;
   int n_mismatched = 0;

   alu_32bit #(.WIDTH(32)) dut (
      .result (result),
      .c_out  (c_out),
      .a      (a),
      .b      (b),
      .aluOp  (aluOp),
      .c_in   (c_in),
      .reset  (reset),
      .CLK    (CLK)
   );

   // Free-running clock, period 10.
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Compare {c_out, result} against an expectation and tally the outcome.
   task automatic check(input string tag, input logic [32:0] got, input logic [32:0] exp);
      n_compared++;
      if (got !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got c_out/result %h, expected %h", tag, got, exp);
      end
   endtask

   // Reference model for the combinational ops; op 111 here is the MOD-less value.
   function automatic logic [32:0] ref_comb(input logic [2:0] op, input logic [31:0] x,
                                            input logic [31:0] y, input logic ci);
      longint unsigned s;
      case (op)
         3'd0: return {1'b0, x & y};
         3'd1: return {1'b0, x | y};
         3'd2: return {1'b0, x ^ y};
         3'd3: return {1'b0, ~(x | y)};
         3'd4: return ($signed(x) < $signed(y)) ? 33'd1 : 33'd0;
         3'd5: begin
            s = 64'(x) + 64'(y) + 64'(ci);
            return s[32:0];
         end
         3'd6: return {(x >= y), x - y};
         default: return 33'd0;
      endcase
   endfunction

   // Drive one combinational vector and check it.
   task automatic comb_vec(input string tag, input logic [2:0] op, input logic [31:0] x,
                           input logic [31:0] y, input logic ci);
      a = x; b = y; aluOp = op; c_in = ci;
      #1;
      check(tag, {c_out, result}, ref_comb(op, x, y, ci));
   endtask

   // Park the FSM in IDLE: one edge with a non-MOD op.
   task automatic go_idle();
      @(negedge CLK);
      aluOp = 3'd0;
      @(negedge CLK);
   endtask

   // Start MOD at the current negedge (FSM in IDLE) and check exact completion
   // time floor(x/y)+2 edges, then the held value for hold_cycles edges.
   task automatic mod_expect(input string tag, input logic [31:0] x, input logic [31:0] y,
                             input int hold_cycles);
      int          lat;
      logic [31:0] exp_rem;
      a = x; b = y; aluOp = 3'b111; c_in = 1'b0;
      lat     = (y == 0) ? 2 : int'(x / y) + 2;
      exp_rem = (y == 0) ? x : x % y;
      repeat (lat - 1) @(posedge CLK);
      #1;
      check({tag, "_busy"}, {c_out, result}, 33'd0);
      @(posedge CLK);
      #1;
      check({tag, "_done"}, {c_out, result}, {1'b0, exp_rem});
      repeat (hold_cycles) begin
         @(posedge CLK);
         #1;
         check({tag, "_hold"}, {c_out, result}, {1'b0, exp_rem});
      end
   endtask

   initial begin
      logic [31:0] rx, ry;
      logic [2:0]  rop;
      int          lat;

      a = '0; b = '0; aluOp = 3'd0; c_in = 1'b0; reset = 1'b1;

      // Reset for two edges; combinational ops must still follow the inputs.
      @(negedge CLK);
      comb_vec("rst_add", 3'd5, 32'd15, 32'd12, 1'b0);
      comb_vec("rst_xor", 3'd2, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0);
      a = 32'd15; b = 32'd6; aluOp = 3'b111;
      @(negedge CLK);
      #1;
      check("rst_mod_zero", {c_out, result}, 33'd0);

      // Directed vectors from the requirements.
      @(negedge CLK);
      comb_vec("and",     3'd0, 32'd12112455, 32'd232112352, 1'b0);
      comb_vec("or",      3'd1, 32'd12112455, 32'd232112352, 1'b0);
      comb_vec("xor",     3'd2, 32'd1212152,  32'd2121122,   1'b0);
      comb_vec("nor",     3'd3, 32'd1212152,  32'd2121122,   1'b0);
      comb_vec("slt_gt",  3'd4, 32'd15, 32'd12, 1'b0);
      comb_vec("slt_lt",  3'd4, 32'd12, 32'd15, 1'b0);
      comb_vec("slt_neg", 3'd4, 32'hFFFF_FFFF, 32'd0, 1'b0);
      comb_vec("add",     3'd5, 32'd15, 32'd12, 1'b0);
      comb_vec("add_wrap",3'd5, 32'hFFFF_FFFF, 32'd0, 1'b1);
      comb_vec("sub",     3'd6, 32'd15, 32'd12, 1'b0);
      comb_vec("sub_neg", 3'd6, 32'd12, 32'd15, 1'b1);
      // Hand-derived constants backing the model on the boundary cases.
      a = 32'hFFFF_FFFF; b = 32'd0; aluOp = 3'd5; c_in = 1'b1; #1;
      check("add_wrap_const", {c_out, result}, {1'b1, 32'd0});
      a = 32'd12; b = 32'd15; aluOp = 3'd6; c_in = 1'b0; #1;
      check("sub_neg_const", {c_out, result}, {1'b0, 32'hFFFF_FFFD});

      // Randomized combinational ops.
      for (int i = 0; i < 300; i++) begin
         rx  = $urandom;
         ry  = (i % 8 == 0) ? rx : $urandom;
         rop = 3'($urandom_range(0, 6));
         comb_vec("rand_comb", rop, rx, ry, 1'($urandom));
      end

`ifdef ALU_MOD_EN
      // Fresh reset, then 15 mod 6 right after release, held 100 cycles.
      @(negedge CLK);
      reset = 1'b1; aluOp = 3'b111; a = 32'd15; b = 32'd6;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      reset = 1'b0;
      mod_expect("mod_15_6", 32'd15, 32'd6, 100);

      // Zero divisor returns a.
      go_idle();
      mod_expect("mod_div0", 32'd1234567, 32'd0, 3);

      // Exact division (remainder 0) and dividend smaller than divisor.
      go_idle();
      mod_expect("mod_exact", 32'd42, 32'd7, 2);
      go_idle();
      mod_expect("mod_small", 32'd5, 32'd9, 2);

      // Operand change in DONE restarts with the new operands.
      @(negedge CLK);
      b = 32'd4;
      repeat (1 + (5 / 4) + 2 - 1) @(posedge CLK);
      #1;
      check("mod_done_chg_busy", {c_out, result}, 33'd0);
      @(posedge CLK);
      #1;
      check("mod_done_chg", {c_out, result}, {1'b0, 32'd1});

      // Randomized MOD with bounded quotient.
      for (int i = 0; i < 20; i++) begin
         go_idle();
         ry = ($urandom & 32'h07FF_FFFF) | 32'd1;
         rx = ry * 32'($urandom_range(0, 20)) + ($urandom % ry);
         mod_expect("mod_rand", rx, ry, 2);
      end

      // Reset during RUN aborts: result reads 0 after the edge.
      go_idle();
      a = 32'd1000; b = 32'd3; aluOp = 3'b111;
      repeat (5) @(posedge CLK);
      @(negedge CLK);
      reset = 1'b1;
      @(posedge CLK);
      #1;
      check("mid_reset", {c_out, result}, 33'd0);
      @(negedge CLK);
      reset = 1'b0;
      @(posedge CLK);
      #1;
      check("post_reset_busy", {c_out, result}, 33'd0);

      // Change b mid-run: one edge back to IDLE, then a full new computation.
      go_idle();
      a = 32'd1000; b = 32'd3; aluOp = 3'b111;
      repeat (5) @(posedge CLK);
      @(negedge CLK);
      b = 32'd7;
      lat = 1000 / 7 + 2;
      repeat (lat) @(posedge CLK);
      #1;
      check("mod_chg_busy", {c_out, result}, 33'd0);
      @(posedge CLK);
      #1;
      check("mod_chg_done", {c_out, result}, {1'b0, 32'd6});
`else
      // Without the MOD feature, op 111 reads zero regardless of clocking.
      for (int i = 0; i < 10; i++) begin
         @(negedge CLK);
         reset = (i == 3);
         a = $urandom; b = $urandom; aluOp = 3'b111; c_in = 1'($urandom);
         repeat (2) @(posedge CLK);
         #1;
         check("mod_off", {c_out, result}, 33'd0);
      end
      reset = 1'b0;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
